butterfly_datapath: RTL and testbench
=====================================

Name: butterfly_datapath

Overview:
- Radix-2 decimation-in-time butterfly datapath. It sits directly downstream of the FFT butterfly controller and consumes that controller's 8-bit signed operand stream plus its load/compute strobes.
- It captures six operands serially: A, B and twiddle W, each as real then imaginary part.
- It computes X = (A + W·B)/2 and Y = (A − W·B)/2 in fixed point with rounding and saturation.
- It streams the four 8-bit results out on consecutive cycles.

Parameters:
- DW, 8: operand and result width, in bits (signed).
- WFRAC, 6: twiddle fractional bits (Q1.6, so 64 = +1.0).

Ports:
- Clock  in  1  single system clock; everything is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- dataIn  in  DW  signed operand from the controller.
- load  in  1  one-cycle strobe; captures dataIn into the next operand slot.
- compute  in  1  one-cycle strobe; starts the butterfly.
- full  out  1  all six operands are captured.
- busy  out  1  a computation or drain is in progress.
- dataOut  out  DW  signed result word.
- outValid  out  1  dataOut is valid this cycle.
- outLast  out  1  marks the 4th (final) result word.

Behaviour:
- Reset (synchronous, active-high): applies at any time, including mid-compute or mid-drain.
  - State goes to IDLE; load count, operand registers and pipeline registers clear to 0.
  - full, busy, dataOut, outValid and outLast are all 0.
- Load order: ldCnt 0..5 selects the slot for each accepted load.
  - Slot sequence: A_re, A_im, B_re, B_im, W_re, W_im.
  - A load is accepted only in IDLE with ldCnt < 6; ldCnt increments on each accepted load.
  - full = (ldCnt == 6), registered.
  - Loads while full, or in any state other than IDLE, are ignored: no state change, no error.
- Compute acceptance: compute is accepted only in IDLE with full = 1 (pre-edge values); otherwise it is ignored.
- Load and compute together in the same cycle with ldCnt = 5: the load is accepted (full rises) and compute is ignored.
- States:
  - IDLE: accepted compute goes to MULT.
  - MULT: goes to ADD.
  - ADD: goes to OUT, with oCnt = 0.
  - OUT: oCnt increments each cycle; after oCnt = 3, return to IDLE with ldCnt = 0 and full = 0.
- busy = 1 in MULT, ADD and OUT.
- MULT stage, all full precision:
  - Pr = B_re·W_re − B_im·W_im
  - Pi = B_re·W_im + B_im·W_re
  - Both fit in 17-bit signed; they are registered.
- Twiddle-product rounding:
  - T = (P + 2^(WFRAC−1)) >>> WFRAC, i.e. round-half-up with an arithmetic shift.
  - T range ±512 (11-bit signed).
- ADD stage:
  - Sx = A + T, Sy = A − T, each 12-bit signed, per real/imag component.
  - Result = sat_DW(S >>> 1), i.e. a floor divide-by-2.
  - Saturation clamps to [−128, 127]; all four results are registered.
- OUT stage:
  - Word order: X_re, X_im, Y_re, Y_im on oCnt 0..3, each with outValid = 1.
  - outLast = 1 only with Y_im.
- Latency: compute sampled at edge N gives the first outValid at cycle N+3 and outLast at N+6. The first load is accepted again at edge N+7.
- Outside OUT: dataOut holds 0 and outValid/outLast are 0.
- Operand registers keep their values until the next load sequence overwrites them.

Test Plan:
- Identity twiddle: A=(10,20), B=(30,−40), W=(64,0), then compute → dataOut 20, −10, −10, 30; outLast on the 4th word; busy low afterwards.
- −j twiddle: A=(10,20), B=(30,−40), W=(0,−64) → T=(−40,−30); outputs −15, −5, 25, 25.
- Positive saturation: A=(127,127), B=(127,127), W=(127,0) → T=(252,252); outputs 127, 127, −63, −63.
- Extreme corner: A=(0,0), B=(−128,0), W=(−128,−128) → T=(256,256); outputs 127, 127, −128, −128.
- Protocol checks:
  - Compute after only 5 loads → no busy, no outValid.
  - A 7th load while full → ignored; the results still match the first six operands.
  - Load and compute in the same cycle at ldCnt = 5 → compute ignored, full = 1.
- Reset mid-drain: assert Reset during the 2nd outValid cycle → next cycle all outputs 0 and full = 0; a fresh 6-load sequence plus compute produces correct results.

Source files
------------

// File: rtl/butterfly_datapath.sv
// ============================================================================
//  Module   : butterfly_datapath
//  Brief    : Radix-2 DIT butterfly; serial operand capture, rounded and
//             saturated X = (A + W*B)/2, Y = (A - W*B)/2, serial result drain.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module butterfly_datapath #(
    parameter int DW    = 8,
    parameter int WFRAC = 6
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] dataIn,
    input  logic          load,
    input  logic          compute,
    output logic          full,
    output logic          busy,
    output logic [DW-1:0] dataOut,
    output logic          outValid,
    output logic          outLast
);

    localparam int c_PW = 2*DW + 1;          // full-precision complex product
    localparam int c_SW = c_PW + 1 - WFRAC;  // rounded twiddle product / sums
    localparam logic [c_PW:0]          c_RND = (c_PW+1)'(2**(WFRAC-1));
    localparam logic signed [c_SW-1:0] c_MAX = {{(c_SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN = {{(c_SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [2:0]             c_NOPS = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_ADD  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_ldcnt;
    logic [1:0]              r_ocnt;
    logic signed [DW-1:0]    r_op [0:5];
    logic signed [c_PW-1:0]  r_pr;
    logic signed [c_PW-1:0]  r_pi;
    logic signed [DW-1:0]    r_xre, r_xim, r_yre, r_yim;
    logic                    r_full, r_busy, r_valid, r_last;
    logic [DW-1:0]           r_dout;

    logic signed [c_PW-1:0]  w_pr, w_pi;
    logic [c_PW:0]           w_prnd, w_pirnd;
    logic signed [c_SW-1:0]  w_tr, w_ti;
    logic signed [c_SW-1:0]  w_sxr, w_sxi, w_syr, w_syi;

    function automatic logic signed [c_PW-1:0] ext_p(input logic signed [DW-1:0] v);
        return {{(c_PW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [c_SW-1:0] ext_s(input logic signed [DW-1:0] v);
        return {{(c_SW-DW){v[DW-1]}}, v};
    endfunction

    // Floor halving followed by clamp to the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat_half(input logic signed [c_SW-1:0] s);
        logic signed [c_SW-1:0] h;
        h = s >>> 1;
        if (h > c_MAX)      return c_MAX[DW-1:0];
        else if (h < c_MIN) return c_MIN[DW-1:0];
        else                return h[DW-1:0];
    endfunction

    // Slots: 0 A_re, 1 A_im, 2 B_re, 3 B_im, 4 W_re, 5 W_im.
    assign w_pr = ext_p(r_op[2]) * ext_p(r_op[4]) - ext_p(r_op[3]) * ext_p(r_op[5]);
    assign w_pi = ext_p(r_op[2]) * ext_p(r_op[5]) + ext_p(r_op[3]) * ext_p(r_op[4]);

    // Round half up: add half an LSB, then the slice is the arithmetic shift.
    assign w_prnd = {r_pr[c_PW-1], r_pr} + c_RND;
    assign w_pirnd = {r_pi[c_PW-1], r_pi} + c_RND;
    assign w_tr = w_prnd[c_PW:WFRAC];
    assign w_ti = w_pirnd[c_PW:WFRAC];

    assign w_sxr = ext_s(r_op[0]) + w_tr;
    assign w_syr = ext_s(r_op[0]) - w_tr;
    assign w_sxi = ext_s(r_op[1]) + w_ti;
    assign w_syi = ext_s(r_op[1]) - w_ti;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ldcnt <= '0;
            r_ocnt  <= '0;
            for (int i = 0; i < 6; i++) r_op[i] <= '0;
            r_pr    <= '0;
            r_pi    <= '0;
            r_xre   <= '0;
            r_xim   <= '0;
            r_yre   <= '0;
            r_yim   <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A load and compute cannot both be accepted: load needs !full.
                    if (load && (r_ldcnt < c_NOPS)) begin
                        r_op[r_ldcnt] <= dataIn;
                        r_ldcnt       <= r_ldcnt + 3'd1;
                        r_full        <= (r_ldcnt == c_NOPS - 3'd1);
                    end else if (compute && r_full) begin
                        r_state <= S_MULT;
                        r_busy  <= 1'b1;
                    end
                end
                S_MULT: begin
                    r_pr    <= w_pr;
                    r_pi    <= w_pi;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_xre   <= sat_half(w_sxr);
                    r_xim   <= sat_half(w_sxi);
                    r_yre   <= sat_half(w_syr);
                    r_yim   <= sat_half(w_syi);
                    r_ocnt  <= '0;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_valid <= 1'b1;
                    r_last  <= (r_ocnt == 2'd3);
                    case (r_ocnt)
                        2'd0:    r_dout <= r_xre;
                        2'd1:    r_dout <= r_xim;
                        2'd2:    r_dout <= r_yre;
                        default: r_dout <= r_yim;
                    endcase
                    r_ocnt <= r_ocnt + 2'd1;
                    if (r_ocnt == 2'd3) begin
                        r_state <= S_IDLE;
                        r_ldcnt <= '0;
                        r_full  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign full     = r_full;
    assign busy     = r_busy;
    assign dataOut  = r_dout;
    assign outValid = r_valid;
    assign outLast  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_butterfly_datapath.sv
// ============================================================================
//  Module   : tb_butterfly_datapath
//  Brief    : Directed-vector bench for butterfly_datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_butterfly_datapath;

    localparam int DW = 8;

    logic          Clock;
    logic          Reset;
    logic [DW-1:0] dataIn;
    logic          load;
    logic          compute;
    logic          full;
    logic          busy;
    logic [DW-1:0] dataOut;
    logic          outValid;
    logic          outLast;

    int n_tests;
    int n_fail;

    butterfly_datapath #(.DW(DW), .WFRAC(6)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .dataIn   (dataIn),
        .load     (load),
        .compute  (compute),
        .full     (full),
        .busy     (busy),
        .dataOut  (dataOut),
        .outValid (outValid),
        .outLast  (outLast)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_op(input int v);
        dataIn = v[DW-1:0];
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic load_n(input int ops[6], input int n);
        for (int i = 0; i < n; i++) load_op(ops[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".outValid"}, int'(outValid), 0);
        check({tag, ".outLast"},  int'(outLast),  0);
        check({tag, ".dataOut"},  int'($signed(dataOut)), 0);
    endtask

    // Issue compute and walk the fixed-latency drain, checking each word.
    task automatic compute_drain(input string tag, input int exp[4]);
        compute = 1'b1;
        tick();
        compute = 1'b0;
        check({tag, ".busy"}, int'(busy), 1);
        tick();
        tick();
        check({tag, ".pre_valid"}, int'(outValid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("%s.valid%0d", tag, k), int'(outValid), 1);
            check($sformatf("%s.data%0d", tag, k), int'($signed(dataOut)), exp[k]);
            check($sformatf("%s.last%0d", tag, k), int'(outLast), (k == 3) ? 1 : 0);
        end
        tick();
        check({tag, ".busy_after"}, int'(busy), 0);
        check({tag, ".full_after"}, int'(full), 0);
        check_idle_outputs({tag, ".after"});
    endtask

    int ops_id[6], ops_mj[6], ops_sat[6], ops_cor[6];
    int exp_id[4], exp_mj[4], exp_sat[4], exp_cor[4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        dataIn  = '0;
        load    = 1'b0;
        compute = 1'b0;

        ops_id  = '{10, 20, 30, -40, 64, 0};     exp_id  = '{20, -10, -10, 30};
        ops_mj  = '{10, 20, 30, -40, 0, -64};    exp_mj  = '{-15, -5, 25, 25};
        ops_sat = '{127, 127, 127, 127, 127, 0}; exp_sat = '{127, 127, -63, -63};
        ops_cor = '{0, 0, -128, 0, -128, -128};  exp_cor = '{127, 127, -128, -128};

        tick();
        tick();
        Reset = 1'b0;
        check("rst.full", int'(full), 0);
        check("rst.busy", int'(busy), 0);
        check_idle_outputs("rst");

        // Identity twiddle.
        load_n(ops_id, 6);
        check("id.full", int'(full), 1);
        compute_drain("id", exp_id);

        // Compute with only five operands is ignored.
        load_n(ops_mj, 5);
        check("five.full", int'(full), 0);
        compute = 1'b1;
        tick();
        compute = 1'b0;
        check("five.busy", int'(busy), 0);
        tick();
        tick();
        tick();
        check("five.busy_late", int'(busy), 0);
        check_idle_outputs("five");

        // Sixth load completes -j twiddle; a seventh while full is ignored.
        load_op(ops_mj[5]);
        check("mj.full", int'(full), 1);
        load_op(99);
        check("seventh.full", int'(full), 1);
        check("seventh.busy", int'(busy), 0);
        compute_drain("mj", exp_mj);

        // Load and compute together at ldCnt = 5: load wins.
        load_n(ops_sat, 5);
        dataIn  = ops_sat[5][DW-1:0];
        load    = 1'b1;
        compute = 1'b1;
        tick();
        load    = 1'b0;
        compute = 1'b0;
        check("both.full", int'(full), 1);
        check("both.busy", int'(busy), 0);
        tick();
        check("both.busy_late", int'(busy), 0);
        check("both.valid", int'(outValid), 0);
        compute_drain("sat", exp_sat);

        // Extreme corner.
        load_n(ops_cor, 6);
        compute_drain("cor", exp_cor);

        // Reset during the second result word.
        load_n(ops_id, 6);
        compute = 1'b1;
        tick();
        compute = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("mid.valid2", int'(outValid), 1);
        check("mid.data2", int'($signed(dataOut)), exp_id[1]);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid.full", int'(full), 0);
        check("mid.busy", int'(busy), 0);
        check_idle_outputs("mid");
        load_n(ops_mj, 6);
        check("mid.reload_full", int'(full), 1);
        compute_drain("mid_mj", exp_mj);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
